// File: rtl/element_stack.sv
// Open-element nesting tracker: consumes finished tags from the tag parser,
// maintains the open-element stack and emits one event per accepted tag.
`ifndef ELE_TAG_BITES
`define ELE_TAG_BITES 8
`endif
`ifndef TAG_IMG
`define TAG_IMG 8'd12
`endif

module element_stack #(
  parameter int                         DEPTH    = 16,
  parameter int                         DEPTH_W  = 5,
  parameter logic [`ELE_TAG_BITES-1:0]  VOID_TAG = `TAG_IMG
) (
  input  logic                       clock,
  input  logic                       state_enable,
  input  logic                       element_done,
  input  logic [`ELE_TAG_BITES-1:0]  element_tag,
  input  logic                       is_closing_tag,
  input  logic                       has_attribute,
  output logic                       event_valid,
  output logic                       event_is_close,
  output logic                       event_is_void,
  output logic [`ELE_TAG_BITES-1:0]  event_tag,
  output logic [DEPTH_W-1:0]         event_depth,
  output logic [3:0]                 event_attr_count,
  output logic [DEPTH_W-1:0]         depth,
  output logic [`ELE_TAG_BITES-1:0]  parent_tag,
  output logic [1:0]                 error,
  output logic                       root_closed
);

  localparam int TW    = `ELE_TAG_BITES;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_UNDERFL  = 2'd2;
  localparam logic [1:0] ERR_MISMATCH = 2'd3;

  typedef enum logic [1:0] {S_WAIT, S_APPLY, S_ERROR} state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t              state_q, state_d;
  logic                done_prev_q, attr_prev_q;
  logic [TW-1:0]       tag_lat_q, tag_lat_d;
  logic                close_lat_q, close_lat_d;
  logic [3:0]          pend_q, pend_d;
  logic [TW-1:0]       stack_q [DEPTH];
  logic [TW-1:0]       stack_d [DEPTH];
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                root_closed_q, root_closed_d;
  logic [1:0]          error_q, error_d;
  logic                ev_valid_q, ev_valid_d;
  logic                ev_close_q, ev_close_d;
  logic                ev_void_q, ev_void_d;
  logic [TW-1:0]       ev_tag_q, ev_tag_d;
  logic [DEPTH_W-1:0]  ev_depth_q, ev_depth_d;
  logic [3:0]          ev_attr_q, ev_attr_d;

  logic                done_rise, attr_rise;
  logic [IDX_W-1:0]    top_idx, push_idx;
  logic [TW-1:0]       parent_w;
  logic [1:0]          err_code;
  logic                is_void_open;

  assign done_rise = element_done & ~done_prev_q;
  assign attr_rise = has_attribute & ~attr_prev_q;
  assign top_idx   = IDX_W'(depth_q - DEPTH_ONE);
  assign push_idx  = IDX_W'(depth_q);
  assign parent_w  = (depth_q == '0) ? '0 : stack_q[top_idx];

  // State register: every flop clears asynchronously, including the stack.
  always_ff @(posedge clock or negedge state_enable) begin
    if (!state_enable) begin
      state_q       <= S_WAIT;
      done_prev_q   <= 1'b0;
      attr_prev_q   <= 1'b0;
      tag_lat_q     <= '0;
      close_lat_q   <= 1'b0;
      pend_q        <= '0;
      stack_q       <= '{default: '0};
      depth_q       <= '0;
      root_closed_q <= 1'b0;
      error_q       <= ERR_NONE;
      ev_valid_q    <= 1'b0;
      ev_close_q    <= 1'b0;
      ev_void_q     <= 1'b0;
      ev_tag_q      <= '0;
      ev_depth_q    <= '0;
      ev_attr_q     <= '0;
    end else begin
      state_q       <= state_d;
      done_prev_q   <= element_done;
      attr_prev_q   <= has_attribute;
      tag_lat_q     <= tag_lat_d;
      close_lat_q   <= close_lat_d;
      pend_q        <= pend_d;
      stack_q       <= stack_d;
      depth_q       <= depth_d;
      root_closed_q <= root_closed_d;
      error_q       <= error_d;
      ev_valid_q    <= ev_valid_d;
      ev_close_q    <= ev_close_d;
      ev_void_q     <= ev_void_d;
      ev_tag_q      <= ev_tag_d;
      ev_depth_q    <= ev_depth_d;
      ev_attr_q     <= ev_attr_d;
    end
  end

  // Classify the latched tag against the current stack; underflow wins over mismatch.
  always_comb begin
    err_code     = ERR_NONE;
    is_void_open = 1'b0;
    if (close_lat_q) begin
      if (depth_q == '0)              err_code = ERR_UNDERFL;
      else if (tag_lat_q != parent_w) err_code = ERR_MISMATCH;
    end else if (tag_lat_q == VOID_TAG) begin
      is_void_open = 1'b1;
    end else if (depth_q == DEPTH_MAX) begin
      err_code = ERR_OVERFLOW;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (done_rise) state_d = S_APPLY;
      S_APPLY: state_d = (err_code != ERR_NONE) ? S_ERROR : S_WAIT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_WAIT;
    endcase
  end

  always_comb begin
    tag_lat_d     = tag_lat_q;
    close_lat_d   = close_lat_q;
    pend_d        = pend_q;
    stack_d       = stack_q;
    depth_d       = depth_q;
    root_closed_d = root_closed_q;
    error_d       = error_q;
    ev_valid_d    = 1'b0;
    ev_close_d    = ev_close_q;
    ev_void_d     = ev_void_q;
    ev_tag_d      = ev_tag_q;
    ev_depth_d    = ev_depth_q;
    ev_attr_d     = ev_attr_q;
    case (state_q)
      S_WAIT: begin
        if (attr_rise) pend_d = sat_inc4(pend_q);
        if (done_rise) begin
          tag_lat_d   = element_tag;
          close_lat_d = is_closing_tag;
        end
      end
      S_APPLY: begin
        if (err_code != ERR_NONE) begin
          error_d = err_code;
          pend_d  = '0;
        end else begin
          ev_valid_d = 1'b1;
          ev_close_d = close_lat_q;
          ev_void_d  = is_void_open;
          ev_tag_d   = tag_lat_q;
          ev_attr_d  = pend_q;
          // An attribute rising on this very edge belongs to the next tag.
          pend_d     = attr_rise ? 4'd1 : 4'd0;
          if (close_lat_q) begin
            ev_depth_d = depth_q;
            depth_d    = depth_q - DEPTH_ONE;
            if (depth_q == DEPTH_ONE) root_closed_d = 1'b1;
          end else if (is_void_open) begin
            ev_depth_d    = depth_q + DEPTH_ONE;
            root_closed_d = 1'b0;
          end else begin
            stack_d[push_idx] = tag_lat_q;
            depth_d           = depth_q + DEPTH_ONE;
            ev_depth_d        = depth_q + DEPTH_ONE;
            root_closed_d     = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign event_valid      = ev_valid_q;
  assign event_is_close   = ev_close_q;
  assign event_is_void    = ev_void_q;
  assign event_tag        = ev_tag_q;
  assign event_depth      = ev_depth_q;
  assign event_attr_count = ev_attr_q;
  assign depth            = depth_q;
  assign parent_tag       = parent_w;
  assign error            = error_q;
  assign root_closed      = root_closed_q;

endmodule

// File: tb/tb_element_stack.sv
// Directed bench for element_stack: expected events are queued by the stimulus
// and popped by an independent monitor whenever event_valid is seen.
`ifndef ELE_TAG_BITES
`define ELE_TAG_BITES 8
`endif
`ifndef TAG_IMG
`define TAG_IMG 8'd12
`endif

module tb_element_stack;

  localparam logic [7:0] DIV = 8'd1;
  localparam logic [7:0] P   = 8'd2;
  localparam logic [7:0] IMG = `TAG_IMG;

  logic        clock = 1'b0;
  logic        state_enable = 1'b0;
  logic        element_done = 1'b0;
  logic [7:0]  element_tag = '0;
  logic        is_closing_tag = 1'b0;
  logic        has_attribute = 1'b0;
  logic        event_valid, event_is_close, event_is_void;
  logic [7:0]  event_tag, parent_tag;
  logic [4:0]  event_depth, depth;
  logic [3:0]  event_attr_count;
  logic [1:0]  error;
  logic        root_closed;

  element_stack #(.DEPTH(16), .DEPTH_W(5), .VOID_TAG(`TAG_IMG)) dut (
    .clock(clock), .state_enable(state_enable), .element_done(element_done),
    .element_tag(element_tag), .is_closing_tag(is_closing_tag),
    .has_attribute(has_attribute), .event_valid(event_valid),
    .event_is_close(event_is_close), .event_is_void(event_is_void),
    .event_tag(event_tag), .event_depth(event_depth),
    .event_attr_count(event_attr_count), .depth(depth),
    .parent_tag(parent_tag), .error(error), .root_closed(root_closed)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       close;
    logic       vd;
    logic [7:0] tag;
    logic [4:0] dep;
    logic [3:0] attr;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int ev_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (state_enable && event_valid) begin
      exp_t e;
      exp_t a;
      ev_count++;
      total++;
      a = '{close: event_is_close, vd: event_is_void, tag: event_tag,
            dep: event_depth, attr: event_attr_count};
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got close=%0d void=%0d tag=%0d depth=%0d attr=%0d expected no event",
                 a.close, a.vd, a.tag, a.dep, a.attr);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL event: got close=%0d void=%0d tag=%0d depth=%0d attr=%0d expected close=%0d void=%0d tag=%0d depth=%0d attr=%0d",
                   a.close, a.vd, a.tag, a.dep, a.attr, e.close, e.vd, e.tag, e.dep, e.attr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_ev(input logic close, input logic vd, input logic [7:0] tag,
                           input logic [4:0] dep, input logic [3:0] attr);
    q.push_back('{close: close, vd: vd, tag: tag, dep: dep, attr: attr});
  endtask

  task automatic send_tag(input logic [7:0] tag, input logic close, input int hi);
    element_tag    = tag;
    is_closing_tag = close;
    element_done   = 1'b1;
    repeat (hi) tick();
    element_done = 1'b0;
    repeat (2) tick();
  endtask

  task automatic attr_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      has_attribute = 1'b1;
      tick();
      has_attribute = 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    check("queue_drained", q.size(), 0);
    state_enable = 1'b0;
    repeat (2) tick();
    state_enable = 1'b1;
    tick();
  endtask

  function automatic logic [63:0] all_outs();
    return {event_valid, event_is_close, event_is_void, event_tag, event_depth,
            event_attr_count, depth, parent_tag, error, root_closed};
  endfunction

  int evc;

  initial begin
    repeat (2) tick();
    check("reset_outputs", all_outs(), 64'd0);
    state_enable = 1'b1;
    tick();

    // Simple nesting
    expect_ev(0, 0, DIV, 5'd1, 4'd0); send_tag(DIV, 0, 3);
    check("depth_open_div", depth, 1);
    expect_ev(0, 0, P, 5'd2, 4'd0);   send_tag(P, 0, 3);
    check("depth_open_p", depth, 2);
    check("parent_p", parent_tag, P);
    expect_ev(1, 0, P, 5'd2, 4'd0);   send_tag(P, 1, 3);
    check("depth_close_p", depth, 1);
    check("parent_div", parent_tag, DIV);
    expect_ev(1, 0, DIV, 5'd1, 4'd0); send_tag(DIV, 1, 3);
    check("depth_close_div", depth, 0);
    check("root_closed_set", root_closed, 1);
    check("error_none", error, 0);

    // Attribute counting
    attr_pulses(3);
    expect_ev(0, 0, DIV, 5'd1, 4'd3); send_tag(DIV, 0, 3);
    check("root_closed_clear", root_closed, 0);
    expect_ev(0, 0, P, 5'd2, 4'd0);   send_tag(P, 0, 3);
    attr_pulses(17);
    expect_ev(1, 0, P, 5'd2, 4'd15);  send_tag(P, 1, 3);
    expect_ev(1, 0, DIV, 5'd1, 4'd0); send_tag(DIV, 1, 3);
    check("depth_after_attr", depth, 0);

    // Void element
    expect_ev(0, 0, DIV, 5'd1, 4'd0); send_tag(DIV, 0, 3);
    expect_ev(0, 1, IMG, 5'd2, 4'd0); send_tag(IMG, 0, 3);
    check("depth_after_img", depth, 1);
    check("parent_after_img", parent_tag, DIV);
    expect_ev(1, 0, DIV, 5'd1, 4'd0); send_tag(DIV, 1, 3);
    check("depth_void_close", depth, 0);

    // Tag code 0 behaves as an ordinary tag
    expect_ev(0, 0, 8'd0, 5'd1, 4'd0); send_tag(8'd0, 0, 3);
    expect_ev(1, 0, 8'd0, 5'd1, 4'd0); send_tag(8'd0, 1, 3);
    check("depth_tag0", depth, 0);

    // Mismatched close freezes
    expect_ev(0, 0, DIV, 5'd1, 4'd0); send_tag(DIV, 0, 3);
    send_tag(P, 1, 3);
    check("error_mismatch", error, 3);
    check("frozen_depth", depth, 1);
    check("frozen_parent", parent_tag, DIV);
    evc = ev_count;
    send_tag(DIV, 1, 3);
    check("no_event_in_error", ev_count, evc);
    check("error_sticky", error, 3);
    do_reset();
    check("reset_clears_error", all_outs(), 64'd0);

    // Underflow
    send_tag(DIV, 1, 3);
    check("error_underflow", error, 2);
    check("depth_underflow", depth, 0);
    do_reset();

    // Overflow on the 17th open
    evc = ev_count;
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) expect_ev(0, 0, DIV, 5'(i), 4'd0);
      send_tag(DIV, 0, 3);
    end
    check("overflow_events", ev_count - evc, 16);
    check("error_overflow", error, 1);
    check("depth_overflow", depth, 16);
    check("parent_overflow", parent_tag, DIV);
    do_reset();

    // element_done held high triggers once
    evc = ev_count;
    expect_ev(0, 0, DIV, 5'd1, 4'd0);
    send_tag(DIV, 0, 10);
    check("held_done_one_event", ev_count - evc, 1);
    check("held_done_depth", depth, 1);
    do_reset();

    // Reset during the apply cycle
    evc = ev_count;
    element_tag = DIV; is_closing_tag = 1'b0; element_done = 1'b1;
    tick();
    state_enable = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 64'd0);
    element_done = 1'b0;
    repeat (2) tick();
    state_enable = 1'b1;
    repeat (3) tick();
    check("reset_apply_no_event", ev_count, evc);
    check("reset_apply_depth", depth, 0);
    check("final_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
